// File: rtl/fb_mem_arbiter_if.sv
// Bus bundle for the framebuffer memory arbiter: display burst port,
// CPU/PRU store port and the single-port SRAM side.
// Handshakes: disp_req is held until the disp_ack pulse; a CPU request is
// accepted in any cycle where cpu_req=1 and cpu_stall=0, otherwise the CPU
// holds every request input unchanged. Read data returns one cycle after
// issue, qualified by the matching rvalid.
interface fb_mem_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  logic                  disp_req;
  logic [ADDR_W-1:0]     disp_addr;
  logic                  disp_ack;
  logic [DATA_W-1:0]     disp_rdata;
  logic                  disp_rvalid;
  logic                  disp_done;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [DATA_W/8-1:0]   cpu_strobe;
  logic                  cpu_stall;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  cpu_rvalid;

  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  // Environment side: display fetcher, CPU and SRAM model.
  modport master (
    output disp_req, disp_addr,
    input  disp_ack, disp_rdata, disp_rvalid, disp_done,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_strobe,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Arbiter side.
  modport slave (
    input  disp_req, disp_addr,
    output disp_ack, disp_rdata, disp_rvalid, disp_done,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_strobe,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/fb_mem_arbiter.sv
// Framebuffer memory arbiter: fixed-length uninterruptible display read
// bursts interleaved with single-beat CPU accesses. Contention in IDLE is
// resolved by alternating grants (last_grant), so neither side starves.
module fb_mem_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 16
) (
  input  logic            clk,
  input  logic            rst,
  fb_mem_arbiter_if.slave bus,
  output logic            dbg_state
);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat;
  logic [ADDR_W-1:0] burst_addr;
  logic              last_grant_disp;   // 0 = CPU was granted last
  logic              disp_tag;
  logic              done_tag;
  logic              cpu_tag;

  logic              disp_grant;
  logic              cpu_grant;
  logic              burst_issue;

  assign dbg_state = state;

  // Arbitration: only in IDLE and never while reset is asserted.
  always_comb begin
    disp_grant  = 1'b0;
    cpu_grant   = 1'b0;
    burst_issue = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        disp_grant = bus.disp_req & (~bus.cpu_req | ~last_grant_disp);
        cpu_grant  = bus.cpu_req  & (~bus.disp_req | last_grant_disp);
      end else begin
        burst_issue = 1'b1;
      end
    end
  end

  // Memory command mux: burst beat, display beat 0, or CPU single beat.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '1;
    bus.mem_addr  = burst_addr;
    bus.mem_wdata = bus.cpu_wdata;
    if (burst_issue) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = burst_addr;
    end else if (disp_grant) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.disp_addr;
    end else if (cpu_grant) begin
      bus.mem_en   = 1'b1;
      bus.mem_we   = bus.cpu_we;
      bus.mem_be   = bus.cpu_we ? bus.cpu_strobe : '1;
      bus.mem_addr = bus.cpu_addr;
    end
  end

  assign bus.cpu_stall   = bus.cpu_req & ~cpu_grant;
  assign bus.disp_ack    = disp_grant;
  assign bus.disp_rdata  = bus.mem_rdata;
  assign bus.cpu_rdata   = bus.mem_rdata;
  assign bus.disp_rvalid = disp_tag;
  assign bus.disp_done   = done_tag;
  assign bus.cpu_rvalid  = cpu_tag;

  // Sequencer FSM plus read-return tags; reset drops any pending return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      beat            <= '0;
      burst_addr      <= '0;
      last_grant_disp <= 1'b0;
      disp_tag        <= 1'b0;
      done_tag        <= 1'b0;
      cpu_tag         <= 1'b0;
    end else begin
      disp_tag <= disp_grant | burst_issue;
      done_tag <= burst_issue & (beat == LAST_BEAT);
      cpu_tag  <= cpu_grant & ~bus.cpu_we;
      case (state)
        IDLE: begin
          if (disp_grant) begin
            burst_addr      <= bus.disp_addr + 1'b1;
            beat            <= BEAT_W'(1);
            last_grant_disp <= 1'b1;
            state           <= BURST;
          end else if (cpu_grant) begin
            last_grant_disp <= 1'b0;
          end
        end
        BURST: begin
          burst_addr <= burst_addr + 1'b1;
          beat       <= beat + 1'b1;
          if (beat == LAST_BEAT) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: a 16-beat instance for arbitration, CPU and
// reset scenarios, and a 4-beat instance for address wrap-around.
module tb_fb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fb_mem_arbiter_if #(.ADDR_W(17), .DATA_W(32)) b16 ();
  fb_mem_arbiter_if #(.ADDR_W(17), .DATA_W(32)) b4 ();
  logic dbg16;
  logic dbg4;

  fb_mem_arbiter #(.ADDR_W(17), .DATA_W(32), .BURST_LEN(16)) u_dut16 (
    .clk(clk), .rst(rst), .bus(b16), .dbg_state(dbg16));
  fb_mem_arbiter #(.ADDR_W(17), .DATA_W(32), .BURST_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(b4), .dbg_state(dbg4));

  // SRAM models: one-cycle read latency; address 7 holds 0x12345678,
  // other words read back as {A5, 0, addr}.
  always @(posedge clk) begin
    if (b16.mem_en && !b16.mem_we)
      b16.mem_rdata <= (b16.mem_addr == 17'h7) ? 32'h12345678 : {8'hA5, 7'h0, b16.mem_addr};
    else
      b16.mem_rdata <= 32'h0BAD0BAD;
  end
  always @(posedge clk) begin
    if (b4.mem_en && !b4.mem_we)
      b4.mem_rdata <= {8'hA5, 7'h0, b4.mem_addr};
    else
      b4.mem_rdata <= 32'h0BAD0BAD;
  end

  typedef struct {
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [16:0] addr;
    logic        ack;
    logic        stall;
    logic        rv;
    logic        done;
    logic [31:0] rdata;
    logic        st;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reference table: contended start, burst at 0x100 then CPU write.
    for (int k = 0; k < 16; k++) begin
      tbl[k].en    = 1'b1;
      tbl[k].we    = 1'b0;
      tbl[k].be    = 4'hF;
      tbl[k].addr  = 17'h00100 + 17'(k);
      tbl[k].ack   = (k == 0);
      tbl[k].stall = 1'b1;
      tbl[k].rv    = (k >= 1);
      tbl[k].done  = 1'b0;
      tbl[k].rdata = {8'hA5, 7'h0, 17'h00100 + 17'(k) - 17'h1};
      tbl[k].st    = (k >= 1);
    end
    tbl[16] = '{en: 1'b1, we: 1'b1, be: 4'b0011, addr: 17'h5, ack: 1'b0, stall: 1'b0,
                rv: 1'b1, done: 1'b1, rdata: {8'hA5, 7'h0, 17'h0010F}, st: 1'b0};
    tbl[17] = '{en: 1'b0, we: 1'b0, be: 4'hF, addr: 17'h0, ack: 1'b0, stall: 1'b0,
                rv: 1'b0, done: 1'b0, rdata: 32'h0, st: 1'b0};

    b16.disp_req = 0; b16.disp_addr = '0; b16.cpu_req = 0; b16.cpu_we = 0;
    b16.cpu_addr = '0; b16.cpu_wdata = '0; b16.cpu_strobe = '0;
    b4.disp_req = 0; b4.disp_addr = '0; b4.cpu_req = 0; b4.cpu_we = 0;
    b4.cpu_addr = '0; b4.cpu_wdata = '0; b4.cpu_strobe = '0;
    rst = 1'b1;
    tick(); tick();

    // Both sides requesting while reset is held.
    b16.disp_req = 1; b16.disp_addr = 17'h00100;
    b16.cpu_req = 1; b16.cpu_we = 1; b16.cpu_addr = 17'h5;
    b16.cpu_wdata = 32'hDEADBEEF; b16.cpu_strobe = 4'b0011;
    @(negedge clk);
    chk("rst_mem_en", b16.mem_en, 0);
    chk("rst_ack", b16.disp_ack, 0);
    chk("rst_stall", b16.cpu_stall, 1);
    chk("rst_disp_rvalid", b16.disp_rvalid, 0);
    chk("rst_disp_done", b16.disp_done, 0);
    chk("rst_cpu_rvalid", b16.cpu_rvalid, 0);
    chk("rst_state", dbg16, 0);
    tick();
    rst = 1'b0;

    // Table-driven contended burst followed by the stalled CPU write.
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk($sformatf("t%0d_en", k), b16.mem_en, tbl[k].en);
      chk($sformatf("t%0d_ack", k), b16.disp_ack, tbl[k].ack);
      chk($sformatf("t%0d_stall", k), b16.cpu_stall, tbl[k].stall);
      chk($sformatf("t%0d_rv", k), b16.disp_rvalid, tbl[k].rv);
      chk($sformatf("t%0d_done", k), b16.disp_done, tbl[k].done);
      chk($sformatf("t%0d_cpu_rv", k), b16.cpu_rvalid, 0);
      chk($sformatf("t%0d_state", k), dbg16, tbl[k].st);
      if (tbl[k].en) begin
        chk($sformatf("t%0d_we", k), b16.mem_we, tbl[k].we);
        chk($sformatf("t%0d_be", k), b16.mem_be, tbl[k].be);
        chk($sformatf("t%0d_addr", k), b16.mem_addr, tbl[k].addr);
      end
      if (tbl[k].we) chk($sformatf("t%0d_wdata", k), b16.mem_wdata, 32'hDEADBEEF);
      if (tbl[k].rv) chk($sformatf("t%0d_rdata", k), b16.disp_rdata, tbl[k].rdata);
      tick();
      if (k == 0) b16.disp_req = 0;
      if (k == 16) b16.cpu_req = 0;
    end

    // Next contention after a CPU grant goes to the display; reset at beat 5.
    b16.disp_req = 1; b16.disp_addr = 17'h00200;
    b16.cpu_req = 1; b16.cpu_we = 0; b16.cpu_addr = 17'h7;
    @(negedge clk);
    chk("alt_ack", b16.disp_ack, 1);
    chk("alt_stall", b16.cpu_stall, 1);
    chk("alt_addr", b16.mem_addr, 17'h00200);
    tick();
    b16.disp_req = 0;
    repeat (4) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_mem_en", b16.mem_en, 0);
    chk("mid_rst_stall", b16.cpu_stall, 1);
    chk("mid_rst_ack", b16.disp_ack, 0);
    tick();
    rst = 1'b0;
    b16.cpu_req = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("ab%0d_en", k), b16.mem_en, 0);
      chk($sformatf("ab%0d_rv", k), b16.disp_rvalid, 0);
      chk($sformatf("ab%0d_done", k), b16.disp_done, 0);
      chk($sformatf("ab%0d_cpu_rv", k), b16.cpu_rvalid, 0);
      tick();
    end

    // Reset with both requesting: display wins; then zero-strobe CPU write.
    rst = 1'b1;
    b16.disp_req = 1; b16.disp_addr = 17'h00300;
    b16.cpu_req = 1; b16.cpu_we = 1; b16.cpu_addr = 17'h9;
    b16.cpu_wdata = 32'h11112222; b16.cpu_strobe = 4'b0000;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ack", b16.disp_ack, 1);
    chk("post_rst_stall", b16.cpu_stall, 1);
    chk("post_rst_addr", b16.mem_addr, 17'h00300);
    tick();
    b16.disp_req = 0;
    repeat (15) tick();
    @(negedge clk);
    chk("zs_en", b16.mem_en, 1);
    chk("zs_we", b16.mem_we, 1);
    chk("zs_be", b16.mem_be, 4'b0000);
    chk("zs_addr", b16.mem_addr, 17'h9);
    chk("zs_stall", b16.cpu_stall, 0);
    chk("zs_done", b16.disp_done, 1);
    tick();
    b16.cpu_req = 0;
    @(negedge clk);
    chk("zs_no_rvalid", b16.cpu_rvalid, 0);
    tick();

    // CPU read then back-to-back write with display idle.
    b16.cpu_req = 1; b16.cpu_we = 0; b16.cpu_addr = 17'h7; b16.cpu_strobe = 4'b0000;
    @(negedge clk);
    chk("rd_en", b16.mem_en, 1);
    chk("rd_we", b16.mem_we, 0);
    chk("rd_be", b16.mem_be, 4'hF);
    chk("rd_addr", b16.mem_addr, 17'h7);
    chk("rd_stall", b16.cpu_stall, 0);
    tick();
    b16.cpu_we = 1; b16.cpu_addr = 17'h8; b16.cpu_wdata = 32'hCAFEF00D; b16.cpu_strobe = 4'b1100;
    @(negedge clk);
    chk("rd_rvalid", b16.cpu_rvalid, 1);
    chk("rd_rdata", b16.cpu_rdata, 32'h12345678);
    chk("rd_disp_rvalid", b16.disp_rvalid, 0);
    chk("wr_stall", b16.cpu_stall, 0);
    chk("wr_en", b16.mem_en, 1);
    chk("wr_we", b16.mem_we, 1);
    chk("wr_be", b16.mem_be, 4'b1100);
    chk("wr_addr", b16.mem_addr, 17'h8);
    chk("wr_wdata", b16.mem_wdata, 32'hCAFEF00D);
    tick();
    b16.cpu_req = 0;
    @(negedge clk);
    chk("wr_no_rvalid", b16.cpu_rvalid, 0);
    tick();

    // Address wrap on the 4-beat instance.
    b4.disp_req = 1; b4.disp_addr = 17'h1FFFE;
    begin
      logic [16:0] wexp[4];
      wexp[0] = 17'h1FFFE; wexp[1] = 17'h1FFFF; wexp[2] = 17'h00000; wexp[3] = 17'h00001;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk($sformatf("w%0d_en", k), b4.mem_en, (k < 4));
        chk($sformatf("w%0d_ack", k), b4.disp_ack, (k == 0));
        chk($sformatf("w%0d_rv", k), b4.disp_rvalid, (k >= 1));
        chk($sformatf("w%0d_done", k), b4.disp_done, (k == 4));
        if (k < 4) chk($sformatf("w%0d_addr", k), b4.mem_addr, wexp[k]);
        if (k >= 1) chk($sformatf("w%0d_rdata", k), b4.disp_rdata, {8'hA5, 7'h0, wexp[k-1]});
        tick();
        if (k == 0) b4.disp_req = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
